// File: rtl/exe_pkg.sv
// Shared definitions for the execute pipeline unit: op-select bit positions,
// FSM states, shift kinds and sideband widths.
package exe_pkg;

  localparam int EXE_FUN_W = 19;
  localparam int WB_SEL_W  = 3;

  localparam int FN_ADD   = 18;
  localparam int FN_SUB   = 17;
  localparam int FN_AND   = 16;
  localparam int FN_OR    = 15;
  localparam int FN_XOR   = 14;
  localparam int FN_SLL   = 13;
  localparam int FN_SRL   = 12;
  localparam int FN_SRA   = 11;
  localparam int FN_SLT   = 10;
  localparam int FN_SLTU  = 9;
  localparam int FN_BEQ   = 8;
  localparam int FN_BNE   = 7;
  localparam int FN_BGE   = 6;
  localparam int FN_BGEU  = 5;
  localparam int FN_BLT   = 4;
  localparam int FN_BLTU  = 3;
  localparam int FN_JALR  = 2;
  localparam int FN_COPY1 = 1;
  localparam int FN_X     = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } sh_kind_t;

  // Malformed selects (none or several bits set) must decode as X.
  function automatic logic is_onehot(input logic [EXE_FUN_W-1:0] f);
    return ($countones(f) == 32'sd1);
  endfunction

endpackage

// File: rtl/exe_alu.sv
// Combinational result and branch-compare logic for one decoded exe_fun.
module exe_alu
  import exe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]      op1,
  input  logic [XLEN-1:0]      op2,
  input  logic [EXE_FUN_W-1:0] exe_fun,
  output logic [XLEN-1:0]      result,
  output logic                 br_taken
);

  localparam int SW = $clog2(XLEN);

  logic [EXE_FUN_W-1:0] w_fun;
  logic [XLEN-1:0]      w_sum;
  logic [XLEN-1:0]      w_diff;
  logic [SW-1:0]        w_shamt;
  logic                 w_eq;
  logic                 w_lt;
  logic                 w_ltu;

  assign w_fun   = is_onehot(exe_fun) ? exe_fun : {EXE_FUN_W{1'b0}};
  assign w_sum   = op1 + op2;
  assign w_diff  = op1 - op2;
  assign w_shamt = op2[SW-1:0];
  assign w_eq    = (op1 == op2);
  assign w_lt    = ($signed(op1) < $signed(op2));
  assign w_ltu   = (op1 < op2);

  // Result/branch select; an all-zero w_fun falls through to the X behaviour.
  always_comb begin
    result   = {XLEN{1'b0}};
    br_taken = 1'b0;
    case (1'b1)
      w_fun[FN_ADD]:   result   = w_sum;
      w_fun[FN_SUB]:   result   = w_diff;
      w_fun[FN_AND]:   result   = op1 & op2;
      w_fun[FN_OR]:    result   = op1 | op2;
      w_fun[FN_XOR]:   result   = op1 ^ op2;
      w_fun[FN_SLL]:   result   = op1 << w_shamt;
      w_fun[FN_SRL]:   result   = op1 >> w_shamt;
      w_fun[FN_SRA]:   result   = $signed(op1) >>> w_shamt;
      w_fun[FN_SLT]:   result   = {{(XLEN-1){1'b0}}, w_lt};
      w_fun[FN_SLTU]:  result   = {{(XLEN-1){1'b0}}, w_ltu};
      w_fun[FN_BEQ]:   br_taken = w_eq;
      w_fun[FN_BNE]:   br_taken = !w_eq;
      w_fun[FN_BGE]:   br_taken = !w_lt;
      w_fun[FN_BGEU]:  br_taken = !w_ltu;
      w_fun[FN_BLT]:   br_taken = w_lt;
      w_fun[FN_BLTU]:  br_taken = w_ltu;
      w_fun[FN_JALR]:  result   = {w_sum[XLEN-1:1], 1'b0};
      w_fun[FN_COPY1]: result   = op1;
      default: begin
        result   = {XLEN{1'b0}};
        br_taken = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/exe_pipe_unit.sv
// Execute stage: valid/ready handshake, optional bit-serial shifter and a
// registered result/sideband stage that holds under backpressure.
module exe_pipe_unit
  import exe_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int SERIAL_SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      op1,
  input  logic [XLEN-1:0]      op2,
  input  logic [EXE_FUN_W-1:0] exe_fun,
  input  logic [4:0]           rd,
  input  logic                 rd_wen,
  input  logic                 mem_we,
  input  logic                 mem_re,
  input  logic [WB_SEL_W-1:0]  wb_sel,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      alu_result,
  output logic                 br_taken,
  output logic [4:0]           rd_o,
  output logic                 rd_wen_o,
  output logic                 mem_we_o,
  output logic                 mem_re_o,
  output logic [WB_SEL_W-1:0]  wb_sel_o
);

  localparam int SW = $clog2(XLEN);
  localparam logic [SW-1:0] CNT_ONE = {{(SW-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic [SW-1:0]         r_cnt;
  logic [XLEN-1:0]       r_shreg;
  sh_kind_t              r_sk;
  logic                  r_out_valid;
  logic [XLEN-1:0]       r_result;
  logic                  r_br;
  logic [4:0]            r_rd;
  logic                  r_rd_wen;
  logic                  r_mem_we;
  logic                  r_mem_re;
  logic [WB_SEL_W-1:0]   r_wb_sel;

  logic [XLEN-1:0]       w_alu_result;
  logic                  w_alu_br;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_is_shift;
  logic                  w_ser_start;
  logic [SW-1:0]         w_shamt;
  sh_kind_t              w_sk;
  logic [XLEN-1:0]       w_sh_next;

  exe_alu #(.XLEN(XLEN)) u_alu (
    .op1      (op1),
    .op2      (op2),
    .exe_fun  (exe_fun),
    .result   (w_alu_result),
    .br_taken (w_alu_br)
  );

  assign w_in_ready  = (r_state == ST_IDLE) && (!r_out_valid || out_ready) && !flush;
  assign w_accept    = in_valid && w_in_ready;
  assign w_shamt     = op2[SW-1:0];
  assign w_is_shift  = is_onehot(exe_fun) &&
                       (exe_fun[FN_SLL] || exe_fun[FN_SRL] || exe_fun[FN_SRA]);
  // Zero-distance shifts take the single-cycle path through the ALU.
  assign w_ser_start = (SERIAL_SHIFT != 32'sd0) && w_is_shift && (w_shamt != {SW{1'b0}});

  // Shift kind captured at accept for the serial engine.
  always_comb begin
    w_sk = SH_SRA;
    if (exe_fun[FN_SLL]) begin
      w_sk = SH_SLL;
    end else if (exe_fun[FN_SRL]) begin
      w_sk = SH_SRL;
    end else begin
      w_sk = SH_SRA;
    end
  end

  // One-bit step of the serial shifter.
  always_comb begin
    w_sh_next = r_shreg;
    case (r_sk)
      SH_SLL:  w_sh_next = {r_shreg[XLEN-2:0], 1'b0};
      SH_SRL:  w_sh_next = {1'b0, r_shreg[XLEN-1:1]};
      SH_SRA:  w_sh_next = {r_shreg[XLEN-1], r_shreg[XLEN-1:1]};
      default: w_sh_next = r_shreg;
    endcase
  end

  // FSM, serial shift sequencing and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {SW{1'b0}};
      r_shreg     <= {XLEN{1'b0}};
      r_sk        <= SH_SLL;
      r_out_valid <= 1'b0;
      r_result    <= {XLEN{1'b0}};
      r_br        <= 1'b0;
      r_rd        <= 5'd0;
      r_rd_wen    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_wb_sel    <= {WB_SEL_W{1'b0}};
    end else if (flush) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {SW{1'b0}};
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_result <= w_alu_result;
            r_br     <= w_alu_br;
            r_rd     <= rd;
            r_rd_wen <= rd_wen;
            r_mem_we <= mem_we;
            r_mem_re <= mem_re;
            r_wb_sel <= wb_sel;
            if (w_ser_start) begin
              r_state     <= ST_SHIFT;
              r_cnt       <= w_shamt;
              r_shreg     <= op1;
              r_sk        <= w_sk;
              r_out_valid <= 1'b0;
            end else begin
              r_out_valid <= 1'b1;
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_shreg <= w_sh_next;
          r_cnt   <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state     <= ST_IDLE;
            r_result    <= w_sh_next;
            r_out_valid <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign alu_result = r_result;
  assign br_taken   = r_br;
  assign rd_o       = r_rd;
  assign rd_wen_o   = r_rd_wen;
  assign mem_we_o   = r_mem_we;
  assign mem_re_o   = r_mem_re;
  assign wb_sel_o   = r_wb_sel;

endmodule

// File: tb/tb_exe_pipe_unit.sv
// Self-checking bench: a single-cycle and a serial-shift instance share stimulus;
// table vectors, random ops against a reference model, and handshake corner cases.
module tb_exe_pipe_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, out_ready;
  logic [31:0] op1, op2;
  logic [18:0] exe_fun;
  logic [4:0]  rd;
  logic        rd_wen, mem_we, mem_re;
  logic [2:0]  wb_sel;

  logic        in_ready0, ov0, br0, rdw0, mw0, mr0;
  logic [31:0] res0;
  logic [4:0]  rd0;
  logic [2:0]  wb0;
  logic        in_ready1, ov1, br1, rdw1, mw1, mr1;
  logic [31:0] res1;
  logic [4:0]  rd1;
  logic [2:0]  wb1;

  int n_vec = 0;
  int n_err = 0;

  exe_pipe_unit #(.XLEN(32), .SERIAL_SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .op1(op1), .op2(op2), .exe_fun(exe_fun), .rd(rd), .rd_wen(rd_wen),
    .mem_we(mem_we), .mem_re(mem_re), .wb_sel(wb_sel), .flush(flush),
    .out_valid(ov0), .out_ready(out_ready), .alu_result(res0), .br_taken(br0),
    .rd_o(rd0), .rd_wen_o(rdw0), .mem_we_o(mw0), .mem_re_o(mr0), .wb_sel_o(wb0)
  );

  exe_pipe_unit #(.XLEN(32), .SERIAL_SHIFT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .op1(op1), .op2(op2), .exe_fun(exe_fun), .rd(rd), .rd_wen(rd_wen),
    .mem_we(mem_we), .mem_re(mem_re), .wb_sel(wb_sel), .flush(flush),
    .out_valid(ov1), .out_ready(out_ready), .alu_result(res1), .br_taken(br1),
    .rd_o(rd1), .rd_wen_o(rdw1), .mem_we_o(mw1), .mem_re_o(mr1), .wb_sel_o(wb1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        br;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Reference: select names by bit position 18..0, shifts by op2[4:0].
  task automatic model(input logic [18:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic br);
    int idx;
    int sh;
    idx = -1;
    r   = 32'h0;
    br  = 1'b0;
    sh  = int'(b[4:0]);
    if ($countones(f) == 1)
      for (int i = 0; i < 19; i++) if (f[i]) idx = i;
    case (idx)
      18: r = a + b;
      17: r = a - b;
      16: r = a & b;
      15: r = a | b;
      14: r = a ^ b;
      13: r = a << sh;
      12: r = a >> sh;
      11: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      10: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9:  r = (a < b) ? 32'd1 : 32'd0;
      8:  br = (a == b);
      7:  br = (a != b);
      6:  br = ($signed(a) >= $signed(b));
      5:  br = (a >= b);
      4:  br = ($signed(a) < $signed(b));
      3:  br = (a < b);
      2:  r = ((a + b) >> 1) << 1;
      1:  r = a;
      default: r = 32'h0;
    endcase
  endtask

  // Latency of the serial-shift instance.
  function automatic int exp_lat(input logic [18:0] f, input logic [31:0] b);
    if ($countones(f) == 1 && (f[13] || f[12] || f[11])) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(5, 0))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return 32'($urandom);
    endcase
  endfunction

  // Entered at a negedge with both units idle; returns at a negedge, both idle.
  task automatic run_op(input string nm, input logic [18:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic eb);
    int lat0, lat1, el;
    logic [10:0] sb;
    el = exp_lat(f, b);
    sb = 11'($urandom);
    chk({nm, ".ready"}, 64'({in_ready0, in_ready1}), 64'(2'b11));
    out_ready = 1'b0;
    in_valid  = 1'b1;
    exe_fun   = f;
    op1       = a;
    op2       = b;
    {rd, rd_wen, mem_we, mem_re, wb_sel} = sb;
    @(negedge clk);
    in_valid = 1'b0;
    lat0 = 0;
    lat1 = 0;
    for (int c = 1; c <= 80; c++) begin
      if (ov0 && lat0 == 0) lat0 = c;
      if (ov1 && lat1 == 0) lat1 = c;
      if (lat0 != 0 && lat1 != 0) break;
      @(negedge clk);
    end
    chk({nm, ".lat0"}, 64'(lat0), 64'(1));
    chk({nm, ".lat1"}, 64'(lat1), 64'(el));
    chk({nm, ".res0"}, 64'({br0, res0}), 64'({eb, er}));
    chk({nm, ".res1"}, 64'({br1, res1}), 64'({eb, er}));
    chk({nm, ".sb0"}, 64'({rd0, rdw0, mw0, mr0, wb0}), 64'(sb));
    chk({nm, ".sb1"}, 64'({rd1, rdw1, mw1, mr1, wb1}), 64'(sb));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run still active at time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [18:0] f;
    logic [31:0] a, b, er;
    logic        eb;
    bit          seen;

    tbl[0]  = '{19'h40000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
    tbl[1]  = '{19'h20000, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0};
    tbl[2]  = '{19'h10000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0};
    tbl[3]  = '{19'h08000, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0};
    tbl[4]  = '{19'h04000, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0};
    tbl[5]  = '{19'h00010, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 1'b1};
    tbl[6]  = '{19'h00008, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 1'b0};
    tbl[7]  = '{19'h00800, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0};
    tbl[8]  = '{19'h02000, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0};
    tbl[9]  = '{19'h01000, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 1'b0};
    tbl[10] = '{19'h00400, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
    tbl[11] = '{19'h00200, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
    tbl[12] = '{19'h00004, 32'h0000_1000, 32'h0000_0003, 32'h0000_1002, 1'b0};
    tbl[13] = '{19'h00002, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    tbl[14] = '{19'h00003, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[15] = '{19'h00000, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0};
    tbl[16] = '{19'h00100, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1};
    tbl[17] = '{19'h00040, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    tbl[18] = '{19'h00020, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    tbl[19] = '{19'h00080, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 1'b0};
    tbl[20] = '{19'h00800, 32'h7FFF_FFF0, 32'h0000_0000, 32'h7FFF_FFF0, 1'b0};
    tbl[21] = '{19'h00001, 32'h1234_5678, 32'h0000_0009, 32'h0000_0000, 1'b0};

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    op1 = 32'h0; op2 = 32'h0; exe_fun = 19'h0;
    rd = 5'd0; rd_wen = 1'b0; mem_we = 1'b0; mem_re = 1'b0; wb_sel = 3'd0;
    repeat (2) @(negedge clk);
    chk("reset.state", 64'({ov1, br1, res1, rd1, rdw1, mw1, mr1, wb1}), 64'(0));
    rst = 1'b0;
    #1 chk("reset.in_ready", 64'({in_ready0, in_ready1}), 64'(2'b11));
    @(negedge clk);

    for (int i = 0; i < 22; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].br);

    for (int k = 0; k < 60; k++) begin
      f = 19'd1 << $urandom_range(18, 0);
      if ($urandom_range(9, 0) == 0) f = 19'($urandom);
      a = pick();
      b = pick();
      model(f, a, b, er, eb);
      run_op($sformatf("rand%0d", k), f, a, b, er, eb);
    end

    // Backpressure hold, then back-to-back accept with no bubble.
    in_valid = 1'b1; exe_fun = 19'h40000; op1 = 32'd3; op2 = 32'd4;
    @(negedge clk);
    in_valid = 1'b0;
    chk("hold.first", 64'({ov1, res1}), 64'({1'b1, 32'd7}));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("hold.cyc%0d", c), 64'({ov1, res1, in_ready1}), 64'({1'b1, 32'd7, 1'b0}));
    end
    in_valid = 1'b1; exe_fun = 19'h04000; op1 = 32'hF0; op2 = 32'hFF; out_ready = 1'b1;
    #1 chk("b2b.in_ready", 64'(in_ready1), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b.second", 64'({ov1, res1}), 64'({1'b1, 32'h0F}));
    @(negedge clk);
    chk("b2b.drain", 64'({ov0, ov1}), 64'(0));
    out_ready = 1'b0;

    // Serial SRA by 4: busy four cycles, valid on the fifth.
    in_valid = 1'b1; exe_fun = 19'h00800; op1 = 32'h8000_0000; op2 = 32'd4;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("sra.busy%0d", c), 64'({in_ready1, ov1}), 64'(0));
      @(negedge clk);
    end
    chk("sra.done", 64'({ov1, res1}), 64'({1'b1, 32'hF800_0000}));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Flush in cycle 2 of SLL by 10 kills the op.
    in_valid = 1'b1; exe_fun = 19'h02000; op1 = 32'd1; op2 = 32'd10; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("flush.busy", 64'(in_ready1), 64'(0));
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1 chk("flush.in_ready", 64'({in_ready1, ov1}), 64'(2'b10));
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (ov1) seen = 1'b1;
    end
    chk("flush.no_valid", 64'(seen), 64'(0));
    out_ready = 1'b0;

    // Asynchronous reset while a result is held.
    in_valid = 1'b1; exe_fun = 19'h40000; op1 = 32'd1; op2 = 32'd2;
    rd = 5'd17; rd_wen = 1'b1; mem_we = 1'b1; mem_re = 1'b1; wb_sel = 3'd5;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rsthold.before", 64'({ov1, res1, rd1}), 64'({1'b1, 32'd3, 5'd17}));
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rsthold.async", 64'({ov0, ov1, br1, res1, rd1, rdw1, mw1, mr1, wb1}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rsthold.in_ready", 64'(in_ready1), 64'(1));

    // Reset in the middle of a serial shift discards it.
    @(negedge clk);
    in_valid = 1'b1; exe_fun = 19'h02000; op1 = 32'd1; op2 = 32'd20; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rstshift.async", 64'(ov1), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rstshift.in_ready", 64'(in_ready1), 64'(1));
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (ov1) seen = 1'b1;
    end
    chk("rstshift.no_valid", 64'(seen), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exe_pipe_unit.md
EXE_PIPE_UNIT -- requirements
Module: exe_pipe_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter SERIAL_SHIFT, default 0; 0 selects single-cycle shifts, 1 selects a 1-bit-per-cycle shifter.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: upstream offers an instruction.
REQ-006 SHALL have port in_ready, output, 1: unit accepts this cycle.
REQ-007 SHALL have ports op1 and op2, input, XLEN each: operands.
REQ-008 SHALL have port exe_fun, input, 19: one-hot op select. Bit 18 down to bit 0 = ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, BEQ, BNE, BGE, BGEU, BLT, BLTU, JALR, COPY1, X.
REQ-009 SHALL have ports rd (5), rd_wen (1), mem_we (1), mem_re (1) and wb_sel (3), all inputs: sideband passed through.
REQ-010 SHALL have port flush, input, 1: discard the held or in-progress instruction.
REQ-011 SHALL have port out_valid, output, 1: result available.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts.
REQ-013 SHALL have port alu_result, output, XLEN: the computed result.
REQ-014 SHALL have port br_taken, output, 1: branch condition true.
REQ-015 SHALL have ports rd_o, rd_wen_o, mem_we_o, mem_re_o and wb_sel_o, all outputs: the registered sideband.

Function
REQ-016 Accept SHALL occur when in_valid and in_ready are both high.
REQ-017 in_ready SHALL equal (state==IDLE) and (!out_valid or out_ready) and !flush.
REQ-018 States SHALL be IDLE and SHIFT; SHIFT exists only when SERIAL_SHIFT=1.
REQ-019 For a non-serial op, the registered result and sideband SHALL appear with out_valid the cycle after accept (latency 1).
REQ-020 While out_valid is high and out_ready is low, all outputs SHALL hold stable.
REQ-021 Op results SHALL be:
- ADD: op1+op2; SUB: op1-op2; both wrap modulo 2^XLEN.
- AND/OR/XOR: bitwise.
- SLL/SRL/SRA: shift op1 by the shamt held in op2 bits [log2(XLEN)-1:0].
- SLT/SLTU: signed/unsigned op1<op2 gives 1, else 0, zero-extended.
- JALR: (op1+op2) with bit0 cleared.
- COPY1: op1.
- Branch ops and X: 0.
REQ-022 br_taken SHALL be 1 only for branch ops whose compare holds: BEQ eq; BNE ne; BLT/BGE signed lt/ge; BLTU/BGEU unsigned lt/ge. Otherwise it SHALL be 0.
REQ-023 If exe_fun is zero or has more than one bit set, the op SHALL be treated as X.
REQ-024 With SERIAL_SHIFT=1, a shift accept with shamt>0 SHALL:
- enter SHIFT with the counter set to shamt;
- shift 1 bit per cycle;
- return to IDLE and raise out_valid in the cycle after the counter reaches 0, giving total latency shamt+1.
REQ-025 With SERIAL_SHIFT=1, a shift with shamt=0 SHALL complete in latency 1.
REQ-026 in_ready SHALL be low throughout SHIFT.
REQ-027 flush SHALL, next edge:
- clear out_valid;
- force IDLE and abort any shift;
- suppress any same-cycle accept.
REQ-028 flush SHALL leave output data don't-care.
REQ-029 When out_valid is high and out_ready is high, a same-cycle accept SHALL load the new instruction with no bubble.

Reset
REQ-030 On rst assertion, out_valid, br_taken, alu_result, all sideband outputs and the shift counter SHALL go to 0 asynchronously, and state SHALL go to IDLE.
REQ-031 Reset mid-shift SHALL discard the instruction; in_ready SHALL be high in the first cycle after rst deasserts.

Structure
REQ-032 Package exe_pkg SHALL hold the exe_fun bit-index constants, the state enum, and the wb_sel width constant.
REQ-033 Combinational op/compare logic SHALL live in sub-module exe_alu (XLEN-parameterised); exe_pipe_unit SHALL hold the handshake, FSM, serial shifter and output register.

Verification
REQ-034 ADD with op1=0xFFFFFFFF, op2=1, out_ready=1 (XLEN=32) -> next cycle out_valid=1, alu_result=0, rd_o equals rd.
REQ-035 BLT with op1=0xFFFFFFFE, op2=1 -> br_taken=1; BLTU with the same operands -> br_taken=0; alu_result=0 in both cases.
REQ-036 SERIAL_SHIFT=1, SRA with op1=0x80000000, op2=4 -> in_ready low for 4 cycles, out_valid on cycle 5, alu_result=0xF8000000.
REQ-037 Result held with out_ready=0 for 3 cycles -> outputs stable and in_ready=0; then out_ready=1 with in_valid=1 -> back-to-back accept, no bubble.
REQ-038 flush asserted mid-shift (cycle 2 of SLL by 10) -> out_valid never rises for that op; in_ready=1 the next cycle.
REQ-039 exe_fun=0x00003 (two bits set) -> alu_result=0 and br_taken=0; rst asserted asynchronously mid-hold -> out_valid=0 immediately.
